// File: rtl/fifo_any_wr_arb_if.sv
// Handshake bundle between requesters, the write arbiter and the multi-port FIFO.
// The arbiter binds to the slave modport; the surrounding environment drives through master.
interface fifo_any_wr_arb_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int W_CNT = 2
);
   logic [NREQ-1:0]  i_req_valid;
   logic [WIDTH-1:0] i_req_data [0:NREQ-1];
   logic [NREQ-1:0]  o_req_ready;
   logic [W_CNT-1:0] o_w_e;
   logic [WIDTH-1:0] o_w_data [0:W_CNT-1];
   logic [W_CNT-1:0] i_w_ack;
   logic             i_w_avail;
   logic             i_flush_req;
   logic             o_fifo_flush;
   logic             o_busy;

   modport slave (
      input  i_req_valid, i_req_data, i_w_ack, i_w_avail, i_flush_req,
      output o_req_ready, o_w_e, o_w_data, o_fifo_flush, o_busy
   );

   modport master (
      output i_req_valid, i_req_data, i_w_ack, i_w_avail, i_flush_req,
      input  o_req_ready, o_w_e, o_w_data, o_fifo_flush, o_busy
   );
endinterface

// File: rtl/fifo_any_wr_arb.sv
// Round-robin write packer for a multi-port FIFO with a flush/hold-off sequencer.
// Optional macro FIFO_ARB_STATS_EN adds saturating accept and stall counters.
module fifo_any_wr_arb #(
   parameter int WIDTH      = 32,
   parameter int NREQ       = 4,
   parameter int W_CNT      = 2,
   parameter int FLUSH_HOLD = 2,
   parameter int GATE_AVAIL = 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   fifo_any_wr_arb_if.slave    bus
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [31:0]         o_stat_acc,
   output logic [31:0]         o_stat_stall
`endif
);

   localparam int PW = $clog2(NREQ);
   localparam int NW = $clog2(W_CNT + 1);

   typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    rr_q, rr_d;
   logic [3:0]       hold_q, hold_d;

   logic [PW-1:0]    lane_req [0:W_CNT-1];
   logic [W_CNT-1:0] lane_vld;
   logic [W_CNT-1:0] w_e;
   logic [NREQ-1:0]  ready;
   logic [NW-1:0]    n_acc;
   logic [PW-1:0]    last_req;
   logic             issue;

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin : pack
      int            cnt;
      logic [PW-1:0] r;
      lane_vld = '0;
      for (int k = 0; k < W_CNT; k++) lane_req[k] = '0;
      cnt = 0;
      r   = '0;
      for (int i = 0; i < NREQ; i++) begin
         r = rr_q + PW'(i);
         if (bus.i_req_valid[r]) begin
            for (int k = 0; k < W_CNT; k++) begin
               if (cnt == k) begin
                  lane_req[k] = r;
                  lane_vld[k] = 1'b1;
               end
            end
            cnt++;
         end
      end
   end

   assign issue = (state_q == RUN) && !i_rst && ((GATE_AVAIL == 0) || bus.i_w_avail);
   assign w_e   = lane_vld & {W_CNT{issue}};

   // Only the unbroken run of acked lanes from lane 0 is accepted.
   always_comb begin : accept
      logic stop;
      stop     = 1'b0;
      n_acc    = '0;
      ready    = '0;
      last_req = rr_q;
      for (int k = 0; k < W_CNT; k++) begin
         if (!stop && w_e[k] && bus.i_w_ack[k]) begin
            n_acc              = n_acc + NW'(1);
            ready[lane_req[k]] = 1'b1;
            last_req           = lane_req[k];
         end else begin
            stop = 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < W_CNT; k++) begin
         bus.o_w_data[k] = w_e[k] ? bus.i_req_data[lane_req[k]] : '0;
      end
   end

   assign bus.o_w_e        = w_e;
   assign bus.o_req_ready  = ready;
   assign bus.o_fifo_flush = (state_q == FLUSH);
   assign bus.o_busy       = !i_rst && (state_q != RUN);

   always_comb begin : fsm_next
      state_d = state_q;
      rr_d    = rr_q;
      hold_d  = hold_q;
      case (state_q)
         RUN: begin
            if (n_acc != '0) rr_d = last_req + 1'b1;
            if (bus.i_flush_req) state_d = FLUSH;
         end
         FLUSH: begin
            rr_d = '0;
            if (FLUSH_HOLD == 0) begin
               state_d = RUN;
            end else begin
               state_d = HOLD;
               hold_d  = 4'(FLUSH_HOLD - 1);
            end
         end
         HOLD: begin
            if (bus.i_flush_req)   state_d = FLUSH;
            else if (hold_q == '0) state_d = RUN;
            else                   hold_d  = hold_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RUN;
         rr_q    <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [31:0] acc_q, stall_q;
   logic [32:0] acc_sum;
   logic        stall_evt;

   assign acc_sum   = {1'b0, acc_q} + 33'(n_acc);
   assign stall_evt = (state_q == RUN) && (|bus.i_req_valid) && (n_acc == '0);

   // Flush leaves the statistics untouched; only reset clears them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         stall_q <= '0;
      end else begin
         acc_q <= acc_sum[32] ? '1 : acc_sum[31:0];
         if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
   end

   assign o_stat_acc   = acc_q;
   assign o_stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_any_wr_arb.sv
// Directed bench for fifo_any_wr_arb (NREQ=4, W_CNT=2, FLUSH_HOLD=2, GATE_AVAIL=1).
// Checks packing, prefix-ack acceptance, round-robin, flush/hold sequencing and reset.
module tb_fifo_any_wr_arb;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int W_CNT = 2;

   logic i_clk;
   logic i_rst;
   int   n_tests;
   int   n_fail;

   fifo_any_wr_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .W_CNT(W_CNT)) bus ();

`ifdef FIFO_ARB_STATS_EN
   logic [31:0] stat_acc;
   logic [31:0] stat_stall;
`endif

   fifo_any_wr_arb #(
      .WIDTH(WIDTH), .NREQ(NREQ), .W_CNT(W_CNT), .FLUSH_HOLD(2), .GATE_AVAIL(1)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
`ifdef FIFO_ARB_STATS_EN
      ,
      .o_stat_acc   (stat_acc),
      .o_stat_stall (stat_stall)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] dval(input int r);
      return 32'hA000_0000 + WIDTH'(r);
   endfunction

   task automatic drive(input logic [3:0] v, input logic [1:0] a, input logic av, input logic fl);
      bus.i_req_valid = v;
      bus.i_w_ack     = a;
      bus.i_w_avail   = av;
      bus.i_flush_req = fl;
      #2;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int r = 0; r < NREQ; r++) bus.i_req_data[r] = dval(r);

      // reset with everything offered
      i_rst = 1'b1;
      drive(4'b1111, 2'b11, 1'b1, 1'b0);
      check("rst_we", bus.o_w_e, 2'b00);
      check("rst_ready", bus.o_req_ready, 4'b0000);
      check("rst_busy", bus.o_busy, 1'b0);
      tick();
      tick();
      check("rst_flush", bus.o_fifo_flush, 1'b0);
      check("rst_we2", bus.o_w_e, 2'b00);
      i_rst = 1'b0;

      // T1: all valid, full ack, rr 0->2->0
      drive(4'b1111, 2'b11, 1'b1, 1'b0);
      check("t1a_we", bus.o_w_e, 2'b11);
      check("t1a_d0", bus.o_w_data[0], dval(0));
      check("t1a_d1", bus.o_w_data[1], dval(1));
      check("t1a_ready", bus.o_req_ready, 4'b0011);
      check("t1a_busy", bus.o_busy, 1'b0);
      tick();
      check("t1b_ready", bus.o_req_ready, 4'b1100);
      check("t1b_d0", bus.o_w_data[0], dval(2));
      tick();
      check("t1c_ready", bus.o_req_ready, 4'b0011);
      tick();
      check("t1d_ready", bus.o_req_ready, 4'b1100);
      tick();

      // T2: sparse valid, only lane 0 acked
      drive(4'b1010, 2'b01, 1'b1, 1'b0);
      check("t2_we", bus.o_w_e, 2'b11);
      check("t2_d0", bus.o_w_data[0], dval(1));
      check("t2_d1", bus.o_w_data[1], dval(3));
      check("t2_ready", bus.o_req_ready, 4'b0010);
      tick();
      drive(4'b1010, 2'b00, 1'b1, 1'b0);
      check("t2b_d0", bus.o_w_data[0], dval(3));
      check("t2b_d1", bus.o_w_data[1], dval(1));
      check("t2b_ready", bus.o_req_ready, 4'b0000);
      tick();

      // T3: non-prefix ack accepts nothing
      drive(4'b1111, 2'b10, 1'b1, 1'b0);
      check("t3_we", bus.o_w_e, 2'b11);
      check("t3_d0", bus.o_w_data[0], dval(2));
      check("t3_ready", bus.o_req_ready, 4'b0000);
      tick();
      drive(4'b1111, 2'b11, 1'b1, 1'b0);
      check("t3b_ready", bus.o_req_ready, 4'b1100);
      tick();

      // T5: avail gating, resume within the same cycle
      drive(4'b1111, 2'b11, 1'b0, 1'b0);
      check("t5_we", bus.o_w_e, 2'b00);
      check("t5_ready", bus.o_req_ready, 4'b0000);
      tick();
      drive(4'b1111, 2'b11, 1'b0, 1'b0);
      check("t5b_we_off", bus.o_w_e, 2'b00);
      drive(4'b1111, 2'b11, 1'b1, 1'b0);
      check("t5b_we_on", bus.o_w_e, 2'b11);
      check("t5b_ready", bus.o_req_ready, 4'b0011);
      tick();

      // T4: flush pulse, hold-off, resume at rr 0
      drive(4'b1111, 2'b11, 1'b1, 1'b1);
      check("f0_ready", bus.o_req_ready, 4'b1100);
      check("f0_flush", bus.o_fifo_flush, 1'b0);
      tick();
      drive(4'b1111, 2'b11, 1'b1, 1'b0);
      check("f1_flush", bus.o_fifo_flush, 1'b1);
      check("f1_busy", bus.o_busy, 1'b1);
      check("f1_we", bus.o_w_e, 2'b00);
      check("f1_ready", bus.o_req_ready, 4'b0000);
      tick();
      check("f2_flush", bus.o_fifo_flush, 1'b0);
      check("f2_busy", bus.o_busy, 1'b1);
      check("f2_we", bus.o_w_e, 2'b00);
      tick();
      check("f3_we", bus.o_w_e, 2'b00);
      check("f3_busy", bus.o_busy, 1'b1);
      tick();
      check("f4_busy", bus.o_busy, 1'b0);
      check("f4_we", bus.o_w_e, 2'b11);
      check("f4_d0", bus.o_w_data[0], dval(0));
      check("f4_ready", bus.o_req_ready, 4'b0011);
      tick();

      // flush request ignored in FLUSH, honoured in HOLD
      drive(4'b0000, 2'b00, 1'b1, 1'b1);
      check("f5_we", bus.o_w_e, 2'b00);
      check("f5_d0", bus.o_w_data[0], 32'h0);
      tick();
      drive(4'b0000, 2'b00, 1'b1, 1'b1);
      check("f6_flush", bus.o_fifo_flush, 1'b1);
      tick();
      drive(4'b0000, 2'b00, 1'b1, 1'b1);
      check("f7_flush", bus.o_fifo_flush, 1'b0);
      check("f7_busy", bus.o_busy, 1'b1);
      tick();
      drive(4'b0000, 2'b00, 1'b1, 1'b0);
      check("f8_flush", bus.o_fifo_flush, 1'b1);
      tick();

      // T6: reset while in HOLD
      drive(4'b1111, 2'b00, 1'b1, 1'b0);
      check("f9_busy", bus.o_busy, 1'b1);
      check("f9_flush", bus.o_fifo_flush, 1'b0);
`ifdef FIFO_ARB_STATS_EN
      check("stat_acc", stat_acc, 64'd17);
      check("stat_stall", stat_stall, 64'd3);
`endif
      i_rst = 1'b1;
      #2;
      check("t6_rst_busy", bus.o_busy, 1'b0);
      check("t6_rst_we", bus.o_w_e, 2'b00);
      tick();
      i_rst = 1'b0;
      drive(4'b1111, 2'b00, 1'b1, 1'b0);
      check("t6_busy", bus.o_busy, 1'b0);
      check("t6_flush", bus.o_fifo_flush, 1'b0);
      check("t6_we", bus.o_w_e, 2'b11);
      check("t6_d0", bus.o_w_data[0], dval(0));
`ifdef FIFO_ARB_STATS_EN
      check("t6_stat_acc", stat_acc, 64'd0);
      check("t6_stat_stall", stat_stall, 64'd0);
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
